fifo_to_dram: RTL and testbench

//  Write-side counterpart of the GPU DRAM read path: buffers 32-bit words pushed by a GPU

---
 rtl/fifo_to_dram.sv | 123 ++++++++++++
 tb/tb_fifo_to_dram.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_dram.sv
// fifo_to_dram: buffers pushed 32-bit words in a show-ahead FIFO and drains them to
// SDRAM as Avalon-MM write bursts of up to 2**BURST_POWER words.
module fifo_to_dram #(
  parameter int BURST_POWER     = 3,
  parameter int FIFO_DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] base_addr,
  input  logic [31:0] numWords,
  input  logic        writeVector,
  output logic        done,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_write_data,
  input  logic        master_wait_request,
  output logic [7:0]  master_burst_count,
  input  logic        wrreq,
  input  logic [31:0] data_in,
  output logic        fifo_full
);
  localparam int          DEPTH       = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [31:0] BURST_WORDS = 32'(2 ** BURST_POWER);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state, state_next;
  logic [31:0] curr_address, curr_address_next;
  logic [31:0] words_left, words_left_next;
  logic [7:0]  burst_len, burst_len_next;
  logic [7:0]  beats_left, beats_left_next;
  logic        write_q, write_next;
  logic [31:0] issue_len;

  logic [31:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   usedw;
  logic                       push, pop;

  // usedw never exceeds DEPTH, so its top bit alone means full
  assign fifo_full = usedw[FIFO_DEPTH_LOG2];
  assign push      = wrreq && !fifo_full;
  assign pop       = write_q && !master_wait_request;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      usedw <= usedw + 1'b1;
      else if (pop && !push) usedw <= usedw - 1'b1;
    end
  end

  // The last burst of a transfer may be shorter than the nominal burst length
  assign issue_len = (words_left < BURST_WORDS) ? words_left : BURST_WORDS;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      curr_address <= '0;
      words_left   <= '0;
      burst_len    <= '0;
      beats_left   <= '0;
      write_q      <= 1'b0;
    end else begin
      state        <= state_next;
      curr_address <= curr_address_next;
      words_left   <= words_left_next;
      burst_len    <= burst_len_next;
      beats_left   <= beats_left_next;
      write_q      <= write_next;
    end
  end

  always_comb begin
    state_next        = state;
    curr_address_next = curr_address;
    words_left_next   = words_left;
    burst_len_next    = burst_len;
    beats_left_next   = beats_left;
    write_next        = write_q;
    case (state)
      IDLE: begin
        if (writeVector) begin
          curr_address_next = base_addr;
          words_left_next   = numWords;
        end else if (words_left != 32'd0 && 32'(usedw) >= issue_len) begin
          burst_len_next  = issue_len[7:0];
          beats_left_next = issue_len[7:0];
          write_next      = 1'b1;
          state_next      = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          words_left_next = words_left - 32'd1;
          beats_left_next = beats_left - 8'd1;
          if (beats_left == 8'd1) begin
            write_next        = 1'b0;
            curr_address_next = curr_address + 32'({burst_len, 2'b00});
            state_next        = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign master_address     = curr_address;
  assign master_write       = write_q;
  assign master_write_data  = mem[rd_ptr];
  assign master_burst_count = burst_len;
  assign done               = (words_left == 32'd0);

endmodule

// File: tb/tb_fifo_to_dram.sv
// tb_fifo_to_dram: directed sequence with random data and waitrequest, checking every
// presented beat against a queue-based model of the expected burst stream.
module tb_fifo_to_dram;
  localparam int B   = 8;
  localparam int CAP = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] base_addr;
  logic [31:0] numWords;
  logic        writeVector;
  logic        done;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_write_data;
  logic        master_wait_request;
  logic [7:0]  master_burst_count;
  logic        wrreq;
  logic [31:0] data_in;
  logic        fifo_full;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] model_fifo[$];
  logic [31:0] exp_base;
  int          exp_n;
  int          beat_idx;
  bit          saw_write;
  bit          rand_wait;

  fifo_to_dram #(.BURST_POWER(3), .FIFO_DEPTH_LOG2(10)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .base_addr           (base_addr),
    .numWords            (numWords),
    .writeVector         (writeVector),
    .done                (done),
    .master_address      (master_address),
    .master_write        (master_write),
    .master_write_data   (master_write_data),
    .master_wait_request (master_wait_request),
    .master_burst_count  (master_burst_count),
    .wrreq               (wrreq),
    .data_in             (data_in),
    .fifo_full           (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Bursts tile the transfer contiguously: beat i lives in burst i/B
  function automatic logic [31:0] exp_addr(input int idx);
    return exp_base + 32'(4 * B * (idx / B));
  endfunction

  function automatic logic [31:0] exp_count(input int idx);
    int rem;
    rem = exp_n - B * (idx / B);
    return 32'((rem < B) ? rem : B);
  endfunction

  initial begin
    master_wait_request = 1'b0;
    forever begin
      @(negedge clk);
      master_wait_request = rand_wait ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  // Every cycle the bus presents a write, it must match the next expected beat
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resetn && master_write) begin
        saw_write = 1'b1;
        checkOutput("beat_expected", 32'(beat_idx < exp_n && model_fifo.size() > 0), 32'd1);
        if (beat_idx < exp_n && model_fifo.size() > 0) begin
          checkOutput("address", master_address, exp_addr(beat_idx));
          checkOutput("burst_count", 32'(master_burst_count), exp_count(beat_idx));
          checkOutput("write_data", master_write_data, model_fifo[0]);
          if (!master_wait_request) begin
            void'(model_fifo.pop_front());
            beat_idx++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic wv, input logic [31:0] base, input logic [31:0] n,
                               input logic wr, input logic [31:0] d);
    @(negedge clk);
    #2;
    writeVector = wv;
    base_addr   = base;
    numWords    = n;
    wrreq       = wr;
    data_in     = d;
    if (wv) begin
      exp_base = base;
      exp_n    = int'(n);
      beat_idx = 0;
    end
    if (wr && model_fifo.size() < CAP) model_fifo.push_back(d);
  endtask

  task automatic push_words(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, $urandom);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic waitBeats(input int n, input int budget);
    int k;
    k = 0;
    while (beat_idx < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    checkOutput("beats_reached", 32'(beat_idx), 32'(n));
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    resetn      = 1'b0;
    writeVector = 1'b0;
    wrreq       = 1'b0;
    model_fifo.delete();
    exp_n    = 0;
    beat_idx = 0;
    @(negedge clk);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    writeVector = 1'b0;
    base_addr   = '0;
    numWords    = '0;
    wrreq       = 1'b0;
    data_in     = '0;
    rand_wait   = 1'b0;
    exp_base    = '0;
    exp_n       = 0;
    beat_idx    = 0;
    saw_write   = 1'b0;

    @(negedge clk);
    #2;
    checkOutput("reset_write", 32'(master_write), 32'd0);
    checkOutput("reset_address", master_address, 32'd0);
    checkOutput("reset_burst_count", 32'(master_burst_count), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd1);
    checkOutput("reset_full", 32'(fifo_full), 32'd0);
    resetn = 1'b1;

    // 20 words from 0x1000: bursts of 8, 8, 4
    applyStimulus(1'b1, 32'h1000, 32'd20, 1'b0, 32'd0);
    push_words(20);
    idle(1);
    waitBeats(20, 300);
    checkOutput("t1_done_before_last", 32'(done), 32'd0);
    idle(1);
    checkOutput("t1_done_after_last", 32'(done), 32'd1);

    // Same transfer under random waitrequest
    rand_wait = 1'b1;
    applyStimulus(1'b1, 32'h1000, 32'd20, 1'b0, 32'd0);
    push_words(20);
    idle(1);
    waitBeats(20, 600);
    checkOutput("t2_done_before_last", 32'(done), 32'd0);
    idle(1);
    checkOutput("t2_done_after_last", 32'(done), 32'd1);
    rand_wait = 1'b0;
    idle(2);

    // A burst must not start until all of its words are buffered
    saw_write = 1'b0;
    applyStimulus(1'b1, 32'h8000, 32'd16, 1'b0, 32'd0);
    push_words(5);
    idle(20);
    checkOutput("t3_no_early_burst", 32'(saw_write), 32'd0);
    checkOutput("t3_done_pending", 32'(done), 32'd0);
    push_words(3);
    idle(1);
    waitBeats(8, 50);
    push_words(8);
    idle(1);
    waitBeats(16, 100);
    checkOutput("t3_done_before_last", 32'(done), 32'd0);
    idle(1);
    checkOutput("t3_done_after_last", 32'(done), 32'd1);

    // Fill the FIFO without a transfer; the overflow word is dropped
    saw_write = 1'b0;
    push_words(1023);
    idle(1);
    checkOutput("t4_full_1023", 32'(fifo_full), 32'(model_fifo.size() == CAP));
    push_words(1);
    idle(1);
    checkOutput("t4_full_1024", 32'(fifo_full), 32'(model_fifo.size() == CAP));
    push_words(1);
    idle(1);
    checkOutput("t4_full_1025", 32'(fifo_full), 32'(model_fifo.size() == CAP));
    checkOutput("t4_master_idle", 32'(saw_write), 32'd0);
    applyStimulus(1'b1, 32'h2000, 32'd1024, 1'b0, 32'd0);
    idle(1);
    waitBeats(1024, 3000);
    idle(1);
    checkOutput("t4_done_drained", 32'(done), 32'd1);
    checkOutput("t4_full_drained", 32'(fifo_full), 32'(model_fifo.size() == CAP));
    saw_write = 1'b0;
    applyStimulus(1'b1, 32'h0, 32'd1, 1'b0, 32'd0);
    idle(20);
    checkOutput("t4_dropped_word_absent", 32'(saw_write), 32'd0);

    // Reset asserted while the third beat of a burst is on the bus
    resetDut();
    applyStimulus(1'b1, 32'h3000, 32'd8, 1'b0, 32'd0);
    push_words(8);
    idle(1);
    waitBeats(3, 50);
    checkOutput("t5_mid_burst", 32'(master_write), 32'd1);
    resetn = 1'b0;
    model_fifo.delete();
    exp_n    = 0;
    beat_idx = 0;
    #1;
    checkOutput("t5_reset_write", 32'(master_write), 32'd0);
    checkOutput("t5_reset_done", 32'(done), 32'd1);
    checkOutput("t5_reset_full", 32'(fifo_full), 32'd0);
    checkOutput("t5_reset_address", master_address, 32'd0);
    checkOutput("t5_reset_count", 32'(master_burst_count), 32'd0);
    @(negedge clk);
    #2;
    resetn    = 1'b1;
    saw_write = 1'b0;
    applyStimulus(1'b1, 32'h0, 32'd1, 1'b0, 32'd0);
    idle(20);
    checkOutput("t5_fifo_emptied", 32'(saw_write), 32'd0);
    checkOutput("t5_done_pending", 32'(done), 32'd0);

    // Zero-length transfer never issues a write
    resetDut();
    saw_write = 1'b0;
    applyStimulus(1'b1, 32'h4000, 32'd0, 1'b0, 32'd0);
    push_words(4);
    idle(10);
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_no_write", 32'(saw_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
